// File: rtl/trap_commit_ctrl.sv
// Writeback-stage trap arbiter: picks retire / exception / interrupt / ERTN
// for the WB instruction, strobes the CSR file, flushes and redirects fetch.
module trap_commit_ctrl #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic        wb_esubcode,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry_pc,
    input  logic [31:0] ertn_pc,
    output logic        wb_commit,
    output logic        ex_en,
    output logic [7:0]  ex_ecode,
    output logic        ex_esubcode,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_vaddr,
    output logic        ertn_flush,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        busy,
    output logic [31:0] trap_cnt
);

    typedef enum logic [1:0] {IDLE, REDIRECT, HOLDOFF} state_t;

    typedef struct packed {
        logic exc;
        logic intr;
        logic ertn;
    } trap_ev_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] trap_cnt_q;
    logic        cnt_inc;
    trap_ev_t    ev;

    // Decode is gated by rstn so every output reads 0 while reset is held,
    // even though the IDLE outputs are otherwise a function of live WB inputs.
    always_comb begin
        ev      = '0;
        ev.exc  = rstn & wb_valid & wb_ex;
        ev.intr = rstn & wb_valid & ~wb_ex & has_int & ~wb_ertn;
        ev.ertn = rstn & wb_valid & ~wb_ex & wb_ertn;
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        hold_d      = hold_q;
        cnt_inc     = 1'b0;
        wb_commit   = 1'b0;
        ex_en       = 1'b0;
        ex_ecode    = 8'h00;
        ex_esubcode = 1'b0;
        ex_pc       = 32'h0;
        ex_vaddr    = 32'h0;
        ertn_flush  = 1'b0;
        flush       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;

        unique case (state_q)
            IDLE: begin
                wb_commit = rstn & wb_valid & ~wb_ex;
                if (ev.exc) begin
                    ex_en       = 1'b1;
                    ex_ecode    = {2'b00, wb_ecode};
                    ex_esubcode = wb_esubcode;
                    ex_pc       = wb_pc;
                    ex_vaddr    = wb_vaddr;
                end else if (ev.intr) begin
                    // Interrupt retires the WB instruction; ecode 0 is INT.
                    ex_en = 1'b1;
                    ex_pc = wb_pc;
                end else if (ev.ertn) begin
                    ertn_flush = 1'b1;
                end
                if (ev.exc || ev.intr || ev.ertn) begin
                    flush    = 1'b1;
                    cnt_inc  = ev.exc | ev.intr;
                    target_d = ev.ertn ? ertn_pc : ex_entry_pc;
                    state_d  = REDIRECT;
                end
            end
            REDIRECT: begin
                flush       = 1'b1;
                redir_valid = 1'b1;
                redir_pc    = target_q;
                if (redir_ready) begin
                    hold_d  = HOLD_INIT;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                hold_d = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    hold_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            target_q   <= 32'h0;
            hold_q     <= 4'd0;
            trap_cnt_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            if (cnt_inc) trap_cnt_q <= trap_cnt_q + 32'd1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign trap_cnt = trap_cnt_q;

endmodule

// File: tb/tb_trap_commit_ctrl.sv
// Directed bench for trap_commit_ctrl: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_trap_commit_ctrl;

    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_valid, wb_ex, wb_esubcode, wb_ertn, has_int, redir_ready;
    logic [31:0] wb_pc, wb_vaddr, ex_entry_pc, ertn_pc;
    logic [5:0]  wb_ecode;
    logic        wb_commit, ex_en, ex_esubcode, ertn_flush, flush, redir_valid, busy;
    logic [7:0]  ex_ecode;
    logic [31:0] ex_pc, ex_vaddr, redir_pc, trap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    trap_commit_ctrl #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .rstn(rstn),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_ertn(wb_ertn),
        .has_int(has_int), .ex_entry_pc(ex_entry_pc), .ertn_pc(ertn_pc),
        .wb_commit(wb_commit), .ex_en(ex_en), .ex_ecode(ex_ecode),
        .ex_esubcode(ex_esubcode), .ex_pc(ex_pc), .ex_vaddr(ex_vaddr),
        .ertn_flush(ertn_flush), .flush(flush), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready), .busy(busy),
        .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_ex = 0; wb_ertn = 0; has_int = 0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_vaddr = 0;
    endtask

    // Let a pending redirect complete and wait (bounded) for IDLE.
    task automatic drain();
        int n;
        clear_wb();
        redir_ready = 1;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        n_checks++;
        if (busy) begin n_fail++; $display("FAIL drain_timeout busy=%0b after %0d cycles, want 0", busy, n); end
    endtask

    task automatic test_reset();
        rstn = 0; clear_wb(); redir_ready = 1; ex_entry_pc = 32'h1C008000; ertn_pc = 0;
        wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B;
        #12;
        n_checks++; if (ex_en !== 0)     begin n_fail++; $display("FAIL rst_ex_en got %0b want 0", ex_en); end
        n_checks++; if (wb_commit !== 0) begin n_fail++; $display("FAIL rst_commit got %0b want 0", wb_commit); end
        n_checks++; if (flush !== 0 || redir_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL rst_ctrl flush=%0b rv=%0b busy=%0b want 0", flush, redir_valid, busy); end
        n_checks++; if (trap_cnt !== 0)  begin n_fail++; $display("FAIL rst_cnt got %h want 0", trap_cnt); end
        clear_wb();
        @(negedge clk); rstn = 1;
        tick();
    endtask

    task automatic test_exception();
        wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 0;
        wb_pc = 32'h1C000100; wb_vaddr = 32'h00001234; ex_entry_pc = 32'h1C008000;
        redir_ready = 1;
        #1;
        n_checks++; if (ex_en !== 1 || ex_ecode !== 8'h0B) begin n_fail++; $display("FAIL exc_strobe ex_en=%0b ecode=%h want 1/0b", ex_en, ex_ecode); end
        n_checks++; if (ex_pc !== 32'h1C000100 || ex_vaddr !== 32'h00001234) begin n_fail++; $display("FAIL exc_fields pc=%h vaddr=%h", ex_pc, ex_vaddr); end
        n_checks++; if (wb_commit !== 0 || flush !== 1) begin n_fail++; $display("FAIL exc_commit commit=%0b flush=%0b want 0/1", wb_commit, flush); end
        tick(); clear_wb();
        n_checks++; if (redir_valid !== 1 || redir_pc !== 32'h1C008000) begin n_fail++; $display("FAIL exc_redir rv=%0b pc=%h want 1/1c008000", redir_valid, redir_pc); end
        n_checks++; if (trap_cnt !== 1) begin n_fail++; $display("FAIL exc_cnt got %0d want 1", trap_cnt); end
        for (int i = 0; i < H; i++) begin
            tick();
            n_checks++; if (busy !== 1 || redir_valid !== 0 || flush !== 0) begin n_fail++; $display("FAIL exc_hold%0d busy=%0b rv=%0b flush=%0b want 1/0/0", i, busy, redir_valid, flush); end
        end
        tick();
        n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL exc_idle busy=%0b want 0 at T+2+H", busy); end
    endtask

    task automatic test_interrupt();
        wb_valid = 1; has_int = 1; wb_pc = 32'h1C000200; wb_vaddr = 32'hFFFF0000;
        ex_entry_pc = 32'h1C009000;
        #1;
        n_checks++; if (ex_en !== 1 || ex_ecode !== 0 || wb_commit !== 1) begin n_fail++; $display("FAIL int_strobe ex_en=%0b ecode=%h commit=%0b want 1/0/1", ex_en, ex_ecode, wb_commit); end
        n_checks++; if (ex_vaddr !== 0 || ex_pc !== 32'h1C000200) begin n_fail++; $display("FAIL int_fields vaddr=%h pc=%h", ex_vaddr, ex_pc); end
        tick();
        n_checks++; if (redir_pc !== 32'h1C009000) begin n_fail++; $display("FAIL int_redir pc=%h want 1c009000", redir_pc); end
        drain();
        n_checks++; if (trap_cnt !== 2) begin n_fail++; $display("FAIL int_cnt got %0d want 2", trap_cnt); end
        wb_valid = 0; has_int = 1;
        #1;
        n_checks++; if (ex_en !== 0 || wb_commit !== 0) begin n_fail++; $display("FAIL int_novalid ex_en=%0b commit=%0b want 0/0", ex_en, wb_commit); end
        tick();
        n_checks++; if (busy !== 0 || trap_cnt !== 2) begin n_fail++; $display("FAIL int_novalid_state busy=%0b cnt=%0d want 0/2", busy, trap_cnt); end
        clear_wb();
    endtask

    task automatic test_ertn();
        wb_valid = 1; wb_ertn = 1; has_int = 1; wb_pc = 32'h1C000300;
        ertn_pc = 32'h1C000204; ex_entry_pc = 32'h1C00A000;
        #1;
        n_checks++; if (ertn_flush !== 1 || ex_en !== 0 || wb_commit !== 1) begin n_fail++; $display("FAIL ertn_strobe ertn=%0b ex_en=%0b commit=%0b want 1/0/1", ertn_flush, ex_en, wb_commit); end
        tick();
        wb_ertn = 0;
        n_checks++; if (redir_pc !== 32'h1C000204 || ertn_flush !== 0) begin n_fail++; $display("FAIL ertn_redir pc=%h ertn=%0b want 1c000204/0", redir_pc, ertn_flush); end
        n_checks++; if (trap_cnt !== 2) begin n_fail++; $display("FAIL ertn_cnt got %0d want 2", trap_cnt); end
        tick();
        for (int i = 0; i < H; i++) begin
            n_checks++; if (ex_en !== 0 || wb_commit !== 0 || busy !== 1) begin n_fail++; $display("FAIL ertn_hold%0d ex_en=%0b commit=%0b busy=%0b want 0/0/1", i, ex_en, wb_commit, busy); end
            tick();
        end
        n_checks++; if (ex_en !== 1 || ex_ecode !== 0 || wb_commit !== 1) begin n_fail++; $display("FAIL ertn_deferred_int ex_en=%0b ecode=%h commit=%0b want 1/0/1", ex_en, ex_ecode, wb_commit); end
        tick();
        n_checks++; if (redir_pc !== 32'h1C00A000 || trap_cnt !== 3) begin n_fail++; $display("FAIL ertn_int_redir pc=%h cnt=%0d want 1c00a000/3", redir_pc, trap_cnt); end
        drain();
    endtask

    task automatic test_priority();
        wb_valid = 1; wb_ex = 1; has_int = 1; wb_ertn = 1;
        wb_ecode = 6'h08; wb_esubcode = 1; wb_pc = 32'h1C000400; wb_vaddr = 32'hDEAD0000;
        #1;
        n_checks++; if (ex_en !== 1 || ertn_flush !== 0 || wb_commit !== 0) begin n_fail++; $display("FAIL prio_strobe ex_en=%0b ertn=%0b commit=%0b want 1/0/0", ex_en, ertn_flush, wb_commit); end
        n_checks++; if (ex_ecode !== 8'h08 || ex_esubcode !== 1 || ex_vaddr !== 32'hDEAD0000) begin n_fail++; $display("FAIL prio_fields ecode=%h sub=%0b vaddr=%h", ex_ecode, ex_esubcode, ex_vaddr); end
        tick();
        drain();
        n_checks++; if (trap_cnt !== 4) begin n_fail++; $display("FAIL prio_cnt got %0d want 4", trap_cnt); end
    endtask

    task automatic test_stall_and_async_reset();
        redir_ready = 0;
        wb_valid = 1; wb_ex = 1; wb_ecode = 6'h01; ex_entry_pc = 32'h1C00B000;
        tick();
        for (int i = 0; i < 5; i++) begin
            wb_ex = i[0]; ex_entry_pc = 32'h2000_0000 + i;
            #1;
            n_checks++; if (redir_valid !== 1 || redir_pc !== 32'h1C00B000 || flush !== 1) begin n_fail++; $display("FAIL stall%0d rv=%0b pc=%h flush=%0b want 1/1c00b000/1", i, redir_valid, redir_pc, flush); end
            n_checks++; if (ex_en !== 0 || wb_commit !== 0) begin n_fail++; $display("FAIL stall_ignore%0d ex_en=%0b commit=%0b want 0/0", i, ex_en, wb_commit); end
            tick();
        end
        #2 rstn = 0;
        #1;
        n_checks++; if (redir_valid !== 0 || busy !== 0 || flush !== 0) begin n_fail++; $display("FAIL async_rst rv=%0b busy=%0b flush=%0b want 0", redir_valid, busy, flush); end
        n_checks++; if (trap_cnt !== 0) begin n_fail++; $display("FAIL async_rst_cnt got %0d want 0", trap_cnt); end
        clear_wb(); redir_ready = 1;
        @(negedge clk); rstn = 1;
        tick();
    endtask

    task automatic test_wrap();
        force dut.trap_cnt_q = 32'hFFFFFFFF;
        #1 release dut.trap_cnt_q;
        #1;
        n_checks++; if (trap_cnt !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffff", trap_cnt); end
        wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0C; ex_entry_pc = 32'h1C008000;
        tick();
        n_checks++; if (trap_cnt !== 0) begin n_fail++; $display("FAIL wrap_cnt got %h want 0", trap_cnt); end
        drain();
        wb_valid = 1; wb_ertn = 1; ertn_pc = 32'h1C000500;
        tick();
        drain();
        n_checks++; if (trap_cnt !== 0) begin n_fail++; $display("FAIL wrap_ertn_cnt got %h want 0", trap_cnt); end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt();
        test_ertn();
        test_priority();
        test_stall_and_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
